// File: rtl/demux1t4_5_buf.sv
// Buffered 1-to-4 demux: steers each accepted beat into one of four per-channel FIFOs.
// One cycle push-to-head latency; input stalls only when the selected channel is full or on flush.

module demux1t4_5_buf_fifo #(
  parameter int WIDTH = 5,
  parameter int DEPTH = 2,
  localparam int PW = $clog2(DEPTH),
  localparam int OW = PW + 1
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             flush_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  output logic             vld_o,
  output logic [WIDTH-1:0] data_o,
  output logic [OW-1:0]    occ_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [OW-1:0]    occ_q, occ_d;
  logic             full;
  logic             do_push;
  logic             do_pop;

  assign full    = (occ_q == OW'(DEPTH));
  assign vld_o   = (occ_q != '0);
  assign do_push = push_i && !full && !flush_i;
  assign do_pop  = pop_i && vld_o && !flush_i;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    occ_d    = occ_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      occ_d    = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + PW'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + PW'(1);
      unique case ({do_push, do_pop})
        2'b10:   occ_d = occ_q + OW'(1);
        2'b01:   occ_d = occ_q - OW'(1);
        default: occ_d = occ_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      occ_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      occ_q    <= occ_d;
    end
  end

  // Storage is left uncleared; an empty channel masks its head to zero instead.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= data_i;
  end

  assign data_o = vld_o ? mem_q[rd_ptr_q] : '0;
  assign occ_o  = occ_q;

endmodule

module demux1t4_5_buf #(
  parameter int WIDTH = 5,
  parameter int DEPTH = 2
) (
  input  logic                             clk,
  input  logic                             rstn,
  input  logic                             in_valid,
  output logic                             in_ready,
  input  logic [WIDTH-1:0]                 in_data,
  input  logic [1:0]                       in_sel,
  input  logic                             flush,
  output logic [3:0]                       out_valid,
  input  logic [3:0]                       out_ready,
  output logic [4*WIDTH-1:0]               out_data,
  output logic [4*($clog2(DEPTH)+1)-1:0]   occ,
  output logic [7:0]                       overflow_cnt
);

  localparam int OW = $clog2(DEPTH) + 1;

  logic [OW-1:0] occ_w [4];
  logic [7:0]    ovf_q, ovf_d;

  // A same-cycle pop on the selected channel deliberately does not free a slot here.
  assign in_ready = !flush && (occ_w[in_sel] < OW'(DEPTH));

  for (genvar k = 0; k < 4; k++) begin : g_ch
    logic push_k;
    assign push_k = in_valid && in_ready && (in_sel == 2'(k));

    demux1t4_5_buf_fifo #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH)
    ) u_fifo (
      .clk     (clk),
      .rstn    (rstn),
      .flush_i (flush),
      .push_i  (push_k),
      .data_i  (in_data),
      .pop_i   (out_ready[k]),
      .vld_o   (out_valid[k]),
      .data_o  (out_data[k*WIDTH +: WIDTH]),
      .occ_o   (occ_w[k])
    );

    assign occ[k*OW +: OW] = occ_w[k];
  end

  always_comb begin
    ovf_d = ovf_q;
    if (in_valid && !in_ready && !flush && (ovf_q != 8'hFF)) ovf_d = ovf_q + 8'd1;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) ovf_q <= '0;
    else       ovf_q <= ovf_d;
  end

  assign overflow_cnt = ovf_q;

endmodule

// File: tb/tb_demux1t4_5_buf.sv
// Directed table-driven bench for demux1t4_5_buf plus hand-written flush, saturation and async-reset sequences.
module tb_demux1t4_5_buf;

  logic        clk;
  logic        rstn;
  logic        in_valid;
  logic        in_ready;
  logic [4:0]  in_data;
  logic [1:0]  in_sel;
  logic        flush;
  logic [3:0]  out_valid;
  logic [3:0]  out_ready;
  logic [19:0] out_data;
  logic [7:0]  occ;
  logic [7:0]  overflow_cnt;

  int n_vec = 0;
  int n_bad = 0;

  demux1t4_5_buf #(.WIDTH(5), .DEPTH(2)) dut (
    .clk          (clk),
    .rstn         (rstn),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_data      (in_data),
    .in_sel       (in_sel),
    .flush        (flush),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_data     (out_data),
    .occ          (occ),
    .overflow_cnt (overflow_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        vld;
    logic [1:0]  sel;
    logic [4:0]  dat;
    logic [3:0]  ordy;
    logic        ir;
    logic [3:0]  ov;
    logic [19:0] od;
    logic [7:0]  oc;
    logic [7:0]  ovf;
  } vec_t;

  vec_t tbl[$];

  function automatic logic [19:0] od4(input logic [4:0] c3, input logic [4:0] c2,
                                      input logic [4:0] c1, input logic [4:0] c0);
    return {c3, c2, c1, c0};
  endfunction

  function automatic logic [7:0] oc4(input logic [1:0] o3, input logic [1:0] o2,
                                     input logic [1:0] o1, input logic [1:0] o0);
    return {o3, o2, o1, o0};
  endfunction

  task automatic add(input logic vld, input logic [1:0] sel, input logic [4:0] dat,
                     input logic [3:0] ordy, input logic ir, input logic [3:0] ov,
                     input logic [19:0] od, input logic [7:0] oc, input logic [7:0] ovf);
    vec_t v;
    v.vld = vld; v.sel = sel; v.dat = dat; v.ordy = ordy;
    v.ir = ir; v.ov = ov; v.od = od; v.oc = oc; v.ovf = ovf;
    tbl.push_back(v);
  endtask

  task automatic drive(input logic vld, input logic [1:0] sel, input logic [4:0] dat,
                       input logic fl, input logic [3:0] ordy);
    in_valid  = vld;
    in_sel    = sel;
    in_data   = dat;
    flush     = fl;
    out_ready = ordy;
  endtask

  task automatic check(input string name, input logic ir, input logic [3:0] ov,
                       input logic [19:0] od, input logic [7:0] oc, input logic [7:0] ovf);
    n_vec++;
    if (in_ready !== ir || out_valid !== ov || out_data !== od || occ !== oc || overflow_cnt !== ovf) begin
      n_bad++;
      $display("FAIL %s: got rdy=%b vld=%b dat=%h occ=%h ovf=%0d, want rdy=%b vld=%b dat=%h occ=%h ovf=%0d",
               name, in_ready, out_valid, out_data, occ, overflow_cnt, ir, ov, od, oc, ovf);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rstn = 1'b0;
    drive(1'b0, 2'd0, 5'h00, 1'b0, 4'b0000);

    // Expected values are what the outputs show before the edge that applies the vector's inputs.
    add(0, 2'd0, 5'h00, 4'b0000, 1, 4'b0000, od4(0, 0, 0, 0),          oc4(0, 0, 0, 0), 8'd0);
    add(1, 2'd2, 5'h15, 4'b0000, 1, 4'b0000, od4(0, 0, 0, 0),          oc4(0, 0, 0, 0), 8'd0);
    add(0, 2'd0, 5'h00, 4'b0000, 1, 4'b0100, od4(0, 5'h15, 0, 0),      oc4(0, 1, 0, 0), 8'd0);
    add(1, 2'd0, 5'h01, 4'b0000, 1, 4'b0100, od4(0, 5'h15, 0, 0),      oc4(0, 1, 0, 0), 8'd0);
    add(1, 2'd0, 5'h02, 4'b0000, 1, 4'b0101, od4(0, 5'h15, 0, 5'h01),  oc4(0, 1, 0, 1), 8'd0);
    add(1, 2'd0, 5'h03, 4'b0000, 0, 4'b0101, od4(0, 5'h15, 0, 5'h01),  oc4(0, 1, 0, 2), 8'd0);
    add(0, 2'd0, 5'h00, 4'b0001, 0, 4'b0101, od4(0, 5'h15, 0, 5'h01),  oc4(0, 1, 0, 2), 8'd1);
    add(0, 2'd0, 5'h00, 4'b0001, 1, 4'b0101, od4(0, 5'h15, 0, 5'h02),  oc4(0, 1, 0, 1), 8'd1);
    add(0, 2'd0, 5'h00, 4'b0001, 1, 4'b0100, od4(0, 5'h15, 0, 0),      oc4(0, 1, 0, 0), 8'd1);
    add(0, 2'd0, 5'h00, 4'b0100, 1, 4'b0100, od4(0, 5'h15, 0, 0),      oc4(0, 1, 0, 0), 8'd1);
    add(1, 2'd1, 5'h10, 4'b0000, 1, 4'b0000, od4(0, 0, 0, 0),          oc4(0, 0, 0, 0), 8'd1);
    for (int i = 0; i < 10; i++) begin
      logic [4:0] hd;
      hd = (i == 0) ? 5'h10 : 5'(8'h0A + i - 1);
      add(1, 2'd1, 5'(8'h0A + i), 4'b0010, 1, 4'b0010, od4(0, 0, hd, 0), oc4(0, 0, 1, 0), 8'd1);
    end
    add(0, 2'd1, 5'h00, 4'b0010, 1, 4'b0010, od4(0, 0, 5'h13, 0),      oc4(0, 0, 1, 0), 8'd1);
    add(0, 2'd0, 5'h00, 4'b0000, 1, 4'b0000, od4(0, 0, 0, 0),          oc4(0, 0, 0, 0), 8'd1);
    add(1, 2'd3, 5'h03, 4'b0000, 1, 4'b0000, od4(0, 0, 0, 0),          oc4(0, 0, 0, 0), 8'd1);
    add(1, 2'd3, 5'h04, 4'b0000, 1, 4'b1000, od4(5'h03, 0, 0, 0),      oc4(1, 0, 0, 0), 8'd1);
    add(0, 2'd3, 5'h00, 4'b0000, 0, 4'b1000, od4(5'h03, 0, 0, 0),      oc4(2, 0, 0, 0), 8'd1);
    add(1, 2'd0, 5'h1F, 4'b0000, 1, 4'b1000, od4(5'h03, 0, 0, 0),      oc4(2, 0, 0, 0), 8'd1);
    add(0, 2'd0, 5'h00, 4'b0000, 1, 4'b1001, od4(5'h03, 0, 0, 5'h1F),  oc4(2, 0, 0, 1), 8'd1);

    #12;
    rstn = 1'b1;
    tick();

    foreach (tbl[i]) begin
      drive(tbl[i].vld, tbl[i].sel, tbl[i].dat, 1'b0, tbl[i].ordy);
      #1;
      check($sformatf("vec%0d", i), tbl[i].ir, tbl[i].ov, tbl[i].od, tbl[i].oc, tbl[i].ovf);
      tick();
    end

    // Flush: load ch0 and ch2 to two entries each, then flush with a live input beat.
    drive(1'b1, 2'd0, 5'h05, 1'b0, 4'b0000); #1;
    check("fl_load0", 1, 4'b1001, od4(5'h03, 0, 0, 5'h1F), oc4(2, 0, 0, 1), 8'd1);
    tick();
    drive(1'b1, 2'd2, 5'h06, 1'b0, 4'b0000); #1;
    check("fl_load1", 1, 4'b1001, od4(5'h03, 0, 0, 5'h1F), oc4(2, 0, 0, 2), 8'd1);
    tick();
    drive(1'b1, 2'd2, 5'h07, 1'b0, 4'b0000); #1;
    check("fl_load2", 1, 4'b1101, od4(5'h03, 5'h06, 0, 5'h1F), oc4(2, 1, 0, 2), 8'd1);
    tick();
    drive(1'b1, 2'd1, 5'h09, 1'b1, 4'b1111); #1;
    check("fl_pulse", 0, 4'b1101, od4(5'h03, 5'h06, 0, 5'h1F), oc4(2, 2, 0, 2), 8'd1);
    tick();
    drive(1'b0, 2'd1, 5'h00, 1'b0, 4'b0000); #1;
    check("fl_after", 1, 4'b0000, od4(0, 0, 0, 0), oc4(0, 0, 0, 0), 8'd1);
    tick();

    // Saturation: fill ch0, then keep pushing into it.
    drive(1'b1, 2'd0, 5'h11, 1'b0, 4'b0000); tick();
    drive(1'b1, 2'd0, 5'h12, 1'b0, 4'b0000); tick();
    drive(1'b1, 2'd0, 5'h13, 1'b0, 4'b0000);
    for (int i = 0; i < 300; i++) begin
      tick();
      if (i == 99)
        check("ovf_mid", 0, 4'b0001, od4(0, 0, 0, 5'h11), oc4(0, 0, 0, 2), 8'd101);
      if (i == 252)
        check("ovf_254", 0, 4'b0001, od4(0, 0, 0, 5'h11), oc4(0, 0, 0, 2), 8'd254);
    end
    check("ovf_sat", 0, 4'b0001, od4(0, 0, 0, 5'h11), oc4(0, 0, 0, 2), 8'd255);

    // Asynchronous reset between edges must clear outputs immediately.
    #3;
    rstn = 1'b0;
    #1;
    check("async_rst", 1, 4'b0000, od4(0, 0, 0, 0), oc4(0, 0, 0, 0), 8'd0);
    tick();
    rstn = 1'b1;
    drive(1'b1, 2'd1, 5'h0B, 1'b0, 4'b0000); #1;
    check("post_rst_push", 1, 4'b0000, od4(0, 0, 0, 0), oc4(0, 0, 0, 0), 8'd0);
    tick();
    drive(1'b0, 2'd0, 5'h00, 1'b0, 4'b0000); #1;
    check("post_rst_head", 1, 4'b0010, od4(0, 0, 5'h0B, 0), oc4(0, 0, 1, 0), 8'd0);
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
